// File: rtl/slv_rst_ctrl_pkg.sv
// Shared types and helpers for the subordinate reset controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   rst_state_e  - per-subordinate sequencer state
//   RstCntWidth  - width of the per-subordinate reset event counter
//   phase_done() - "this is the last cycle of a timed phase" test
package slv_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        RESET   = 2'd2,
        SETTLE  = 2'd3
    } rst_state_e;

    localparam int                     RstCntWidth = 8;
    localparam logic [RstCntWidth-1:0] RstCntMax   = 8'hFF;

    // A timed phase with limit lim lasts max(lim,1) cycles. cnt counts the
    // cycles already spent in the phase, starting at 0 on entry, so the
    // current cycle is the last one when cnt+1 reaches the limit. A limit of
    // 0 behaves like 1: the phase is left after its first cycle.
    function automatic logic phase_done(input logic [31:0] cnt,
                                        input logic [31:0] lim);
        return (lim == 32'd0) || ((cnt + 32'd1) >= lim);
    endfunction

endpackage

// File: rtl/slv_rst_ctrl_if.sv
// Guard/subordinate handshake bundle for slv_rst_ctrl, one bit per subordinate.
// Latency: n/a (wires only).
// Backpressure: n/a.
//
// slave  modport: controller view (requests/isolation status in, reset/status out)
// master modport: guard + isolation stage view
interface slv_rst_ctrl_if
    import slv_rst_ctrl_pkg::*;
#(
    parameter int NumSub = 1
);
    logic [NumSub-1:0]                  rst_req_i;
    logic [NumSub-1:0]                  rst_stat_o;
    logic [NumSub-1:0]                  sub_rst_no;
    logic [NumSub-1:0]                  isolate_o;
    logic [NumSub-1:0]                  isolated_i;
    logic [NumSub-1:0]                  timeout_clr_i;
    logic [NumSub-1:0]                  timeout_o;
    logic [NumSub-1:0][RstCntWidth-1:0] rst_cnt_o;

    modport slave (
        input  rst_req_i,
        input  isolated_i,
        input  timeout_clr_i,
        output rst_stat_o,
        output sub_rst_no,
        output isolate_o,
        output timeout_o,
        output rst_cnt_o
    );

    modport master (
        output rst_req_i,
        output isolated_i,
        output timeout_clr_i,
        input  rst_stat_o,
        input  sub_rst_no,
        input  isolate_o,
        input  timeout_o,
        input  rst_cnt_o
    );

endinterface

// File: rtl/slv_rst_ctrl_fsm.sv
// Reset sequencer for one subordinate: isolate, drain, reset, settle.
// Latency: isolate_o/rst_stat_o rise 1 cycle after rst_req_i is sampled; all outputs registered.
// Backpressure: requests outside IDLE are dropped, drain is bounded by the latched timeout.
//
// Ports: clk_i/rst_ni clock and async active-low reset; rst_req_i, isolated_i,
// timeout_clr_i per-subordinate controls; drain/hold/settle config, latched on
// request acceptance; isolate_o, sub_rst_no, rst_stat_o, timeout_o, rst_cnt_o
// outputs. Optional event counter: SLV_RST_CTRL_CNT_EN.
module slv_rst_ctrl_fsm
    import slv_rst_ctrl_pkg::*;
#(
    parameter int CntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rst_req_i,
    input  logic                   isolated_i,
    input  logic                   timeout_clr_i,
    input  logic [CntWidth-1:0]    drain_timeout_i,
    input  logic [CntWidth-1:0]    hold_cycles_i,
    input  logic [CntWidth-1:0]    settle_cycles_i,
    output logic                   isolate_o,
    output logic                   sub_rst_no,
    output logic                   rst_stat_o,
    output logic                   timeout_o,
    output logic [RstCntWidth-1:0] rst_cnt_o
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    rst_state_e          state;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] drain_q;
    logic [CntWidth-1:0] hold_q;
    logic [CntWidth-1:0] settle_q;
    logic [CntWidth-1:0] lim;
    logic                cnt_last;
    logic                timeout_set;

    // Limit of whichever timed phase is active.
    always_comb begin
        lim = '0;
        case (state)
            ISOLATE: lim = drain_q;
            RESET:   lim = hold_q;
            SETTLE:  lim = settle_q;
            default: lim = '0;
        endcase
    end

    assign cnt_last = phase_done(32'(cnt), 32'(lim));

    // Drain forced by the limit; a clean drain in the same cycle wins.
    assign timeout_set = (state == ISOLATE) && !isolated_i && cnt_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            drain_q    <= '0;
            hold_q     <= '0;
            settle_q   <= '0;
            isolate_o  <= 1'b0;
            sub_rst_no <= 1'b1;
            rst_stat_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rst_req_i) begin
                        state      <= ISOLATE;
                        cnt        <= '0;
                        drain_q    <= drain_timeout_i;
                        hold_q     <= hold_cycles_i;
                        settle_q   <= settle_cycles_i;
                        isolate_o  <= 1'b1;
                        rst_stat_o <= 1'b1;
                    end
                end
                ISOLATE: begin
                    if (isolated_i || cnt_last) begin
                        state      <= RESET;
                        cnt        <= '0;
                        sub_rst_no <= 1'b0;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                RESET: begin
                    if (cnt_last) begin
                        state      <= SETTLE;
                        cnt        <= '0;
                        sub_rst_no <= 1'b1;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                SETTLE: begin
                    if (cnt_last) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        isolate_o  <= 1'b0;
                        rst_stat_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    isolate_o  <= 1'b0;
                    sub_rst_no <= 1'b1;
                    rst_stat_o <= 1'b0;
                end
            endcase

            // Set beats clear when both land in the same cycle.
            if (timeout_set) begin
                timeout_o <= 1'b1;
            end else if (timeout_clr_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

`ifdef SLV_RST_CTRL_CNT_EN
    // Counts accepted requests, saturating so a long-lived count never wraps.
    logic [RstCntWidth-1:0] rst_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt_q <= '0;
        end else if ((state == IDLE) && rst_req_i && (rst_cnt_q != RstCntMax)) begin
            rst_cnt_q <= rst_cnt_q + RstCntWidth'(1);
        end
    end

    assign rst_cnt_o = rst_cnt_q;
`else
    assign rst_cnt_o = '0;
`endif

endmodule

// File: rtl/slv_rst_ctrl.sv
// Subordinate reset controller: one isolate/reset/settle sequencer per subordinate.
// Latency: sequencer outputs registered (1 cycle from request); irq_o combinational from timeout flags.
// Backpressure: none; requests arriving while a sequence is running are dropped.
//
// Ports: clk_i, rst_ni (async active-low); drain_timeout_i, hold_cycles_i,
// settle_cycles_i shared config; bus (slv_rst_ctrl_if.slave) per-subordinate
// handshake; irq_o OR of all sticky timeout flags.
// Build option: SLV_RST_CTRL_CNT_EN enables the saturating reset event counters.
module slv_rst_ctrl
    import slv_rst_ctrl_pkg::*;
#(
    parameter int NumSub   = 1,
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CntWidth-1:0] drain_timeout_i,
    input  logic [CntWidth-1:0] hold_cycles_i,
    input  logic [CntWidth-1:0] settle_cycles_i,
    slv_rst_ctrl_if.slave       bus,
    output logic                irq_o
);

    logic [NumSub-1:0]                  isolate_w;
    logic [NumSub-1:0]                  sub_rst_nw;
    logic [NumSub-1:0]                  rst_stat_w;
    logic [NumSub-1:0]                  timeout_w;
    logic [NumSub-1:0][RstCntWidth-1:0] rst_cnt_w;

    for (genvar g = 0; g < NumSub; g++) begin : g_sub
        slv_rst_ctrl_fsm #(
            .CntWidth (CntWidth)
        ) u_fsm (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .rst_req_i       (bus.rst_req_i[g]),
            .isolated_i      (bus.isolated_i[g]),
            .timeout_clr_i   (bus.timeout_clr_i[g]),
            .drain_timeout_i (drain_timeout_i),
            .hold_cycles_i   (hold_cycles_i),
            .settle_cycles_i (settle_cycles_i),
            .isolate_o       (isolate_w[g]),
            .sub_rst_no      (sub_rst_nw[g]),
            .rst_stat_o      (rst_stat_w[g]),
            .timeout_o       (timeout_w[g]),
            .rst_cnt_o       (rst_cnt_w[g])
        );
    end

    assign bus.isolate_o  = isolate_w;
    assign bus.sub_rst_no = sub_rst_nw;
    assign bus.rst_stat_o = rst_stat_w;
    assign bus.timeout_o  = timeout_w;
    assign bus.rst_cnt_o  = rst_cnt_w;

    assign irq_o = |timeout_w;

endmodule

// File: doc/slv_rst_ctrl.md
SLV_RST_CTRL -- requirements
Module: slv_rst_ctrl

Interface
REQ-001 SHALL have parameter NumSub, default 1: number of guarded subordinates.
REQ-002 SHALL have parameter CntWidth, default 8: width of all timing counters and config inputs.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i input 1 clock; rst_ni input 1 async active-low reset.
REQ-004 SHALL have rst_req_i input NumSub: per-subordinate reset request from the guard, level or pulse.
REQ-005 SHALL have rst_stat_o output NumSub: reset sequence in progress, returned to the guard.
REQ-006 SHALL have sub_rst_no output NumSub: active-low reset driven to each subordinate.
REQ-007 SHALL have isolate_o output NumSub: request to the subordinate's isolation stage.
REQ-008 SHALL have isolated_i input NumSub: isolation stage reports no outstanding transactions.
REQ-009 SHALL have drain_timeout_i, hold_cycles_i and settle_cycles_i inputs, each CntWidth wide: drain limit, reset assertion length and post-release settle length in cycles.
REQ-010 SHALL have timeout_clr_i input NumSub: clears sticky timeout flags.
REQ-011 SHALL have timeout_o output NumSub: sticky flag, set when drain was forced by timeout.
REQ-012 SHALL have irq_o output 1: OR of timeout_o.
REQ-013 SHALL have rst_cnt_o output NumSub x 8: reset event counters.

Function
REQ-014 SHALL run one independent FSM per subordinate with states IDLE, ISOLATE, RESET, SETTLE.
REQ-015 SHALL move from IDLE to ISOLATE in the cycle after rst_req_i is sampled high, and latch all three config inputs at that point.
REQ-016 SHALL ignore rst_req_i in all states other than IDLE, with no queuing.
REQ-017 SHALL hold isolate_o high in ISOLATE, RESET and SETTLE, and low in IDLE.
REQ-018 SHALL leave ISOLATE for RESET when isolated_i is high, or when the drain counter equals the latched drain_timeout. If the drain counter reaches the limit, timeout_o SHALL be set.
REQ-019 SHALL treat drain_timeout 0 as an immediate forced reset: ISOLATE lasts exactly 1 cycle and timeout_o is set unless isolated_i is high in that cycle.
REQ-020 SHALL drive sub_rst_no low for exactly max(hold,1) cycles in RESET, then enter SETTLE.
REQ-021 SHALL drive sub_rst_no high in SETTLE for exactly settle cycles, then return to IDLE; settle 0 returns after 1 cycle.
REQ-022 SHALL drive rst_stat_o high whenever the FSM is not in IDLE.
REQ-023 SHALL clear a counter on every state entry; counters SHALL never wrap.
REQ-024 SHALL give set priority to timeout_o when timeout_clr_i and a timeout set occur in the same cycle.
REQ-025 SHALL drive irq_o combinationally from the OR of timeout_o.

Reset
REQ-026 While rst_ni is low, outputs SHALL be: state IDLE, sub_rst_no 1, isolate_o 0, rst_stat_o 0, timeout_o 0, rst_cnt_o 0, counters 0.
REQ-027 SHALL abort any sequence on assertion of rst_ni, with no residual pulse on sub_rst_no.

Configuration
REQ-028 With SLV_RST_CTRL_CNT_EN defined, each rst_cnt_o SHALL increment, saturating at 255, on every IDLE-to-ISOLATE transition.
REQ-029 Without SLV_RST_CTRL_CNT_EN, rst_cnt_o SHALL be tied to 0, SHALL contain no counter flops, and the port SHALL remain present.

Structure
REQ-030 SHALL place the state enum rst_state_e in package slv_rst_ctrl_pkg.
REQ-031 SHALL implement the per-subordinate FSM plus counters as sub-module slv_rst_ctrl_fsm, generated NumSub times. The top level only does the OR for irq_o.

Verification
REQ-032 Case drain=10, hold=4, settle=3; rst_req_i[0] pulsed; isolated_i[0] high 2 cycles later. Required: isolate_o rises 1 cycle after the request; sub_rst_no low for exactly 4 cycles; rst_stat_o low after settle; timeout_o stays 0.
REQ-033 Case isolated_i held 0, drain=5. Required: RESET entered after 5 ISOLATE cycles; timeout_o[0] and irq_o set; timeout_clr_i clears both.
REQ-034 Case hold=0, settle=0, drain=0. Required: sub_rst_no low 1 cycle; whole sequence lasts 3 cycles; timeout_o set.
REQ-035 Case NumSub=2, simultaneous requests with different isolated_i timing. Required: FSMs progress independently; a second rst_req_i[0] during RESET is ignored.
REQ-036 Case rst_ni asserted mid-RESET. Required: sub_rst_no returns to 1 and rst_stat_o to 0 immediately; 300 sequences give rst_cnt_o=255 with the macro defined, 0 without.
